// File: rtl/slow_dac_update_sched.sv
// Write scheduler for the two LTC2666-16 slow DACs: tracks changed setpoints and issues one
// SPI write command per handshake, round-robin, with optional periodic full refresh.
module slow_dac_update_sched #(
  parameter int unsigned NCH     = 16,      // channel indexing below assumes exactly 16
  parameter int unsigned REFRESH = 1000000  // 0 disables refresh
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic                  force_all,
  input  logic [NCH-1:0][15:0]  sout,
  output logic                  cmd_valid,
  input  logic                  cmd_ready,
  output logic                  cmd_chip,
  output logic [2:0]            cmd_addr,
  output logic [15:0]           cmd_data,
  output logic [NCH-1:0]        dirty,
  output logic                  busy
);

  typedef enum logic [1:0] {StIdle, StPick, StIssue} state_e;

  state_e               state_q, state_d;
  logic [3:0]           rr_q;
  logic [NCH-1:0]       dirty_q, dirty_d;
  logic [NCH-1:0][15:0] last_q;
  logic [31:0]          cnt_q, cnt_d;
  logic                 cmd_valid_q, cmd_valid_d;
  logic                 cmd_chip_q;
  logic [2:0]           cmd_addr_q;
  logic [15:0]          cmd_data_q;

  logic                 tick;
  logic                 accept;
  logic                 load;
  logic                 pick_found;
  logic [3:0]           pick_ch;
  logic [3:0]           cur_ch;
  logic [NCH-1:0]       chg;

  assign cur_ch = {cmd_chip_q, cmd_addr_q};
  assign accept = cmd_valid_q & cmd_ready;

  // First dirty channel strictly after rr_q, wrapping 15 -> 0; rr_q itself is tried last.
  always_comb begin
    logic [3:0] idx;
    pick_found = 1'b0;
    pick_ch    = rr_q;
    for (int k = 1; k <= 16; k++) begin
      idx = rr_q + 4'(k);
      if (!pick_found && dirty_q[idx]) begin
        pick_found = 1'b1;
        pick_ch    = idx;
      end
    end
  end

  always_comb begin
    for (int i = 0; i < NCH; i++) begin
      chg[i] = (sout[i] != last_q[i]);
    end
  end

  always_comb begin
    tick  = 1'b0;
    cnt_d = '0;
    if (REFRESH != 0) begin
      tick  = (cnt_q == 32'(REFRESH - 1));
      cnt_d = tick ? '0 : cnt_q + 32'd1;
    end
  end

  // Sets are applied after the accept-clear so a concurrent change or refresh wins.
  always_comb begin
    dirty_d = dirty_q;
    if (accept) dirty_d[cur_ch] = 1'b0;
    dirty_d = dirty_d | chg;
    if (force_all || tick) dirty_d = '1;
  end

  always_comb begin
    state_d     = state_q;
    load        = 1'b0;
    cmd_valid_d = cmd_valid_q;
    unique case (state_q)
      StIdle: begin
        if (en && (|dirty_q)) state_d = StPick;
      end
      StPick: begin
        load    = pick_found;
        state_d = pick_found ? StIssue : StIdle;
        if (pick_found) cmd_valid_d = 1'b1;
      end
      StIssue: begin
        if (cmd_ready) begin
          cmd_valid_d = 1'b0;
          state_d     = (en && (|dirty_d)) ? StPick : StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      rr_q        <= 4'd15;
      dirty_q     <= '1;
      last_q      <= '0;
      cnt_q       <= '0;
      cmd_valid_q <= 1'b0;
      cmd_chip_q  <= 1'b0;
      cmd_addr_q  <= 3'd0;
      cmd_data_q  <= 16'd0;
    end else begin
      state_q     <= state_d;
      dirty_q     <= dirty_d;
      cnt_q       <= cnt_d;
      cmd_valid_q <= cmd_valid_d;
      if (accept) rr_q <= cur_ch;
      if (load) begin
        cmd_chip_q      <= pick_ch[3];
        cmd_addr_q      <= pick_ch[2:0];
        cmd_data_q      <= {~sout[pick_ch][15], sout[pick_ch][14:0]};
        last_q[pick_ch] <= sout[pick_ch];
      end
    end
  end

  assign cmd_valid = cmd_valid_q;
  assign cmd_chip  = cmd_chip_q;
  assign cmd_addr  = cmd_addr_q;
  assign cmd_data  = cmd_data_q;
  assign dirty     = dirty_q;
  assign busy      = (|dirty_q) | cmd_valid_q;

endmodule
